// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one 16x8 combinational memory port
// between the CPU and the loader/debug port.
// Latency: gnt + strobe one cycle after the request is seen in IDLE, done the
// cycle after that, and back in IDLE the cycle after done (3 cycles per access).
// Backpressure: a requester holds req until gnt. The loser of a tie stays pending
// and is served in the next arbitration. Requests are only sampled in IDLE.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata  CPU request; c_gnt/c_done pulses, c_rdata result
//   l_req/l_we/l_addr/l_wdata  loader request; l_gnt/l_done pulses, l_rdata result
//   mem_address/mem_read/mem_write/mem_data_in  registered memory drive
//   mem_data_out               combinational read data from memory
//   busy                       FSM not in IDLE
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic [DATA_W-1:0] l_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // win_q: owner of the current access (1 = loader).
  // last_q: winner of the previous arbitration; reset to loader so the CPU
  // wins the first tie.
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

  logic pick_l;

  // Loader wins when alone, or on a tie when the CPU won last time.
  assign pick_l = l_req & (~c_req | ~last_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (c_req || l_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered-output / datapath next values. Strobes are computed here and
  // registered so the memory never sees combinational paths from requesters.
  always_comb begin
    win_d     = win_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (c_req || l_req) begin
          win_d   = pick_l;
          addr_d  = pick_l ? l_addr  : c_addr;
          wdata_d = pick_l ? l_wdata : c_wdata;
          rd_d    = pick_l ? ~l_we   : ~c_we;
          wr_d    = pick_l ? l_we    : c_we;
        end
      end
      S_ACCESS: begin
        // Capture read data on the edge that closes the access
        if (rd_q) begin
          if (win_q) l_rdata_d = mem_data_out;
          else       c_rdata_d = mem_data_out;
        end
      end
      S_RESP: begin
        last_d = win_q;
      end
      default: ;
    endcase
  end

  // Output decode
  assign c_gnt       = (state_q == S_ACCESS) & ~win_q;
  assign l_gnt       = (state_q == S_ACCESS) &  win_q;
  assign c_done      = (state_q == S_RESP)   & ~win_q;
  assign l_done      = (state_q == S_RESP)   &  win_q;
  assign busy        = (state_q != S_IDLE);
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign c_rdata     = c_rdata_q;
  assign l_rdata     = l_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural 16x8 memory.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Scenarios: reset, CPU read, write-then-read, loader streaming, contention, reset mid-write.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c_req, c_we, l_req, l_we;
  logic [3:0] c_addr, l_addr;
  logic [7:0] c_wdata, l_wdata;
  logic       c_gnt, c_done, l_gnt, l_done;
  logic [7:0] c_rdata, l_rdata;
  logic [3:0] mem_address;
  logic       mem_read, mem_write, busy;
  logic [7:0] mem_data_in, mem_data_out;

  int n_vec = 0;
  int n_err = 0;

  logic       mem_clear;
  logic [7:0] mem_model [16];

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= 8'h00;
      mem_model[12] <= 8'h05;
    end else if (mem_write) begin
      mem_model[mem_address] <= mem_data_in;
    end
  end
  assign mem_data_out = mem_model[mem_address];

  mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  // Wait (bounded) on falling edges until the arbiter is idle.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bit ok;
    rst_n = 1'b0; mem_clear = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 4'h0; c_wdata = 8'h00;
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'h1; l_wdata = 8'h00;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({c_gnt, c_done, l_gnt, l_done, mem_read, mem_write, busy} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {c_gnt, c_done, l_gnt, l_done, mem_read, mem_write, busy});
    end
    n_vec++;
    if ({mem_address, mem_data_in, c_rdata, l_rdata} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0000000",
               {mem_address, mem_data_in, c_rdata, l_rdata});
    end
    rst_n = 1'b1; mem_clear = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({c_gnt, l_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_first_grant: got c,l=%b want 10", {c_gnt, l_gnt});
    end
    c_req = 1'b0; l_req = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL reset_idle_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_cpu_read;
    bit ok;
    c_req = 1'b1; c_we = 1'b0; c_addr = 4'hC;
    @(negedge clk);
    n_vec++;
    if ({c_gnt, mem_read, mem_write, mem_address} !== {3'b110, 4'hC}) begin
      n_err++;
      $display("FAIL cpu_read_access: got gnt,rd,wr,addr=%b,%b,%b,%h want 1,1,0,c",
               c_gnt, mem_read, mem_write, mem_address);
    end
    c_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({c_done, c_gnt, mem_read, c_rdata} !== {3'b100, 8'h05}) begin
      n_err++;
      $display("FAIL cpu_read_resp: got done,gnt,rd,rdata=%b,%b,%b,%h want 1,0,0,05",
               c_done, c_gnt, mem_read, c_rdata);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL cpu_read_idle_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_write_read;
    bit ok;
    l_req = 1'b1; l_we = 1'b1; l_addr = 4'h3; l_wdata = 8'hA5;
    @(negedge clk);
    n_vec++;
    if ({l_gnt, mem_write, mem_read, mem_address, mem_data_in} !== {3'b110, 4'h3, 8'hA5}) begin
      n_err++;
      $display("FAIL wr_access: got gnt,wr,rd,addr,din=%b,%b,%b,%h,%h want 1,1,0,3,a5",
               l_gnt, mem_write, mem_read, mem_address, mem_data_in);
    end
    l_req = 1'b0; l_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({l_done, mem_write, l_rdata} !== {2'b10, 8'h00}) begin
      n_err++;
      $display("FAIL wr_resp: got done,wr,l_rdata=%b,%b,%h want 1,0,00",
               l_done, mem_write, l_rdata);
    end
    wait_idle(ok);
    c_req = 1'b1; c_we = 1'b0; c_addr = 4'h3;
    @(negedge clk);
    c_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({c_done, c_rdata} !== {1'b1, 8'hA5}) begin
      n_err++;
      $display("FAIL wr_then_rd: got done,rdata=%b,%h want 1,a5", c_done, c_rdata);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wr_rd_idle_timeout: busy=%b want 0", busy); end
  endtask

  // Loader streams reads of addr 3 (holds 0xA5); done expected at falling edges 2, 5, 8.
  task automatic test_back_to_back;
    bit ok;
    int ndone = 0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'h3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (c_gnt !== 1'b0) begin
        n_err++; $display("FAIL stream_cgnt: cycle %0d got %b want 0", i, c_gnt);
      end
      if (l_done) begin
        n_vec++;
        if (i != 2 + 3 * ndone || l_rdata !== 8'hA5) begin
          n_err++;
          $display("FAIL stream_done: cycle %0d rdata %h want cycle %0d rdata a5",
                   i, l_rdata, 2 + 3 * ndone);
        end
        ndone++;
        if (ndone == 3) l_req = 1'b0;
      end
    end
    n_vec++;
    if (ndone != 3) begin n_err++; $display("FAIL stream_count: got %0d want 3", ndone); end
    wait_idle(ok);
  endtask

  // Both request continuously; grants expected at falling edges 1,4,7,10 as C,L,C,L.
  task automatic test_contention;
    bit ok;
    int ng = 0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 4'h3;
    l_req = 1'b1; l_we = 1'b0; l_addr = 4'hC;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      n_vec++;
      if (c_gnt && l_gnt) begin
        n_err++; $display("FAIL cont_both_gnt: cycle %0d both high want one", i);
      end
      if (c_gnt || l_gnt) begin
        n_vec++;
        if (i != 1 + 3 * ng || l_gnt !== ng[0]) begin
          n_err++;
          $display("FAIL cont_order: grant %0d cycle %0d l_gnt %b want cycle %0d l_gnt %b",
                   ng, i, l_gnt, 1 + 3 * ng, ng[0]);
        end
        ng++;
        if (ng == 4) begin c_req = 1'b0; l_req = 1'b0; end
      end
    end
    n_vec++;
    if (ng != 4) begin n_err++; $display("FAIL cont_count: got %0d want 4", ng); end
    n_vec++;
    if ({c_rdata, l_rdata} !== 16'hA505) begin
      n_err++; $display("FAIL cont_rdata: got %h want a505", {c_rdata, l_rdata});
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_write;
    c_req = 1'b1; c_we = 1'b1; c_addr = 4'h7; c_wdata = 8'h3C;
    @(negedge clk);
    n_vec++;
    if ({c_gnt, mem_write} !== 2'b11) begin
      n_err++; $display("FAIL rmw_access: got gnt,wr=%b want 11", {c_gnt, mem_write});
    end
    rst_n = 1'b0; c_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mem_write, mem_read, busy, c_done, c_gnt} !== 5'b0) begin
      n_err++;
      $display("FAIL rmw_abort: got wr,rd,busy,done,gnt=%b want 00000",
               {mem_write, mem_read, busy, c_done, c_gnt});
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++;
      if ({c_done, busy} !== 2'b00) begin
        n_err++; $display("FAIL rmw_no_done: got done,busy=%b want 00", {c_done, busy});
      end
    end
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_write_read;
    test_back_to_back;
    test_contention;
    test_reset_mid_write;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
